// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bundle for the sequential binary-to-BCD converter.
// The converter takes the slave modport; the requester takes the master modport.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic                  sign_mode;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;
    logic                  overflow;
    logic [7*DIGITS-1:0]   seg_out;

    modport master (
        output start,
        output sign_mode,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  neg,
        input  overflow,
        input  seg_out
    );

    modport slave (
        input  start,
        input  sign_mode,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output neg,
        output overflow,
        output seg_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary/two's-complement to BCD converter, one bit per clock,
// with active-low seven-segment patterns (leading-zero blanking, minus sign, overflow blank).
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t             state_reg;
    logic [BIN_W-1:0]   mag_reg;
    logic [BCD_W-1:0]   work_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               sign_reg;
    logic               ovf_acc_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               neg_reg;
    logic               overflow_reg;
    logic [BCD_W-1:0]   bcd_reg;

    logic               in_neg;
    logic [BIN_W-1:0]   in_mag;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_next;
    logic [BIN_W-1:0]   mag_next;
    logic               carry_out;

    // The most negative input negates to 2^(BIN_W-1), which still fits as unsigned.
    assign in_neg = bus.sign_mode & bus.bin_in[BIN_W-1];
    assign in_mag = in_neg ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
            logic [3:0] dig;
            assign dig = work_reg[4*gi +: 4];
            assign work_adj[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
    endgenerate

    // A 1 leaving the top digit means the magnitude needs more digits than we have.
    assign carry_out = work_adj[BCD_W-1];
    assign work_next = {work_adj[BCD_W-2:0], mag_reg[BIN_W-1]};
    assign mag_next  = {mag_reg[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mag_reg      <= '0;
            work_reg     <= '0;
            count_reg    <= '0;
            sign_reg     <= 1'b0;
            ovf_acc_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            neg_reg      <= 1'b0;
            overflow_reg <= 1'b0;
            bcd_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mag_reg     <= in_mag;
                        sign_reg    <= in_neg;
                        work_reg    <= '0;
                        ovf_acc_reg <= 1'b0;
                        count_reg   <= CNT_W'(BIN_W);
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg  <= work_next;
                    mag_reg   <= mag_next;
                    if (carry_out) begin
                        ovf_acc_reg <= 1'b1;
                    end
                    count_reg <= count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_reg      <= work_reg;
                    neg_reg      <= sign_reg;
                    overflow_reg <= ovf_acc_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.bcd_out  = bcd_reg;
    assign bus.neg      = neg_reg;
    assign bus.overflow = overflow_reg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0001100;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // upper_zero[d] is set when digit d and every digit above it are zero.
    logic [DIGITS:0]     upper_zero;
    logic [7*DIGITS-1:0] seg_comb;

    always_comb begin
        upper_zero         = '0;
        upper_zero[DIGITS] = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            upper_zero[d] = upper_zero[d+1] & (bcd_reg[4*d +: 4] == 4'd0);
        end
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            if (gi == 0) begin : g_ones
                assign seg_comb[6:0] = overflow_reg ? 7'b1111111 : seg_decode(bcd_reg[3:0]);
            end else begin : g_upper
                logic blank;
                logic minus;
                assign blank = upper_zero[gi];
                // Minus sits on the first blank digit right above the leading nonzero digit.
                assign minus = neg_reg & upper_zero[gi] & ~upper_zero[gi-1];
                assign seg_comb[7*gi +: 7] = overflow_reg ? 7'b1111111 :
                                             minus        ? 7'b1111110 :
                                             blank        ? 7'b1111111 :
                                             seg_decode(bcd_reg[4*gi +: 4]);
            end
        end
    endgenerate

    assign bus.seg_out = seg_comb;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance driven with
// directed vectors; a negedge monitor pops expected results whenever done is seen.
module tb_bin_to_bcd_seq;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0001100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b1111110;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        logic        ovf;
        logic [20:0] seg;
        int          done_edge;
        bit          chk_bcd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q3[$];
    exp_t q2[$];
    exp_t e3;
    exp_t e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if3 ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && if3.done) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done3_unexpected: got done=1 at edge %0d expected no pulse", cyc);
            end else begin
                e3 = q3.pop_front();
                $display("dut3 done at edge %0d bcd=%h neg=%b ovf=%b seg=%b", cyc, if3.bcd_out, if3.neg, if3.overflow, if3.seg_out);
                check("done3_edge", cyc, e3.done_edge);
                if (e3.chk_bcd) check("bcd3", {20'd0, if3.bcd_out}, {20'd0, e3.bcd});
                check("neg3", {31'd0, if3.neg}, {31'd0, e3.neg});
                check("ovf3", {31'd0, if3.overflow}, {31'd0, e3.ovf});
                check("seg3", {11'd0, if3.seg_out}, {11'd0, e3.seg});
            end
        end
        if (!rst && if2.done) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done2_unexpected: got done=1 at edge %0d expected no pulse", cyc);
            end else begin
                e2 = q2.pop_front();
                $display("dut2 done at edge %0d bcd=%h neg=%b ovf=%b seg=%b", cyc, if2.bcd_out, if2.neg, if2.overflow, if2.seg_out);
                check("done2_edge", cyc, e2.done_edge);
                if (e2.chk_bcd) check("bcd2", {24'd0, if2.bcd_out}, {24'd0, e2.bcd[7:0]});
                check("neg2", {31'd0, if2.neg}, {31'd0, e2.neg});
                check("ovf2", {31'd0, if2.overflow}, {31'd0, e2.ovf});
                check("seg2", {18'd0, if2.seg_out}, {18'd0, e2.seg[13:0]});
            end
        end
    end

    // Called at a negedge: raises start for one cycle and records the expected result.
    task automatic issue3(input logic sm, input logic [7:0] v, input logic [11:0] bcd,
                          input logic ng, input logic [20:0] seg);
        exp_t e;
        if3.start = 1'b1;
        if3.sign_mode = sm;
        if3.bin_in = v;
        @(negedge clk);
        if3.start = 1'b0;
        e.bcd = bcd; e.neg = ng; e.ovf = 1'b0; e.seg = seg;
        e.done_edge = cyc + 9; e.chk_bcd = 1'b1;
        q3.push_back(e);
    endtask

    task automatic issue2(input logic sm, input logic [7:0] v, input logic [7:0] bcd,
                          input logic ng, input logic ov, input bit chk, input logic [13:0] seg);
        exp_t e;
        if2.start = 1'b1;
        if2.sign_mode = sm;
        if2.bin_in = v;
        @(negedge clk);
        if2.start = 1'b0;
        e.bcd = {4'd0, bcd}; e.neg = ng; e.ovf = ov; e.seg = {7'd0, seg};
        e.done_edge = cyc + 9; e.chk_bcd = chk;
        q2.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q3.size() != 0 || q2.size() != 0 || if3.busy || if2.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d/%0d pending results expected 0/0", q3.size(), q2.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by edge %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        if3.start = 1'b0; if3.sign_mode = 1'b0; if3.bin_in = '0;
        if2.start = 1'b0; if2.sign_mode = 1'b0; if2.bin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy3", {31'd0, if3.busy}, 32'd0);
        check("rst_done3", {31'd0, if3.done}, 32'd0);
        check("rst_bcd3", {20'd0, if3.bcd_out}, 32'd0);
        check("rst_seg3", {11'd0, if3.seg_out}, {11'd0, SB, SB, S0});
        check("rst_seg2", {18'd0, if2.seg_out}, {18'd0, SB, S0});

        // Unsigned full scale
        issue3(1'b0, 8'd255, 12'h255, 1'b0, {S2, S5, S5});
        wait_idle();

        // Asynchronous reset mid-conversion: aborts, clears outputs, no done
        if3.start = 1'b1; if3.sign_mode = 1'b0; if3.bin_in = 8'd200;
        @(negedge clk);
        if3.start = 1'b0;
        check("abort_busy_before", {31'd0, if3.busy}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, if3.busy}, 32'd0);
        check("abort_done", {31'd0, if3.done}, 32'd0);
        check("abort_bcd", {20'd0, if3.bcd_out}, 32'd0);
        check("abort_seg", {11'd0, if3.seg_out}, {11'd0, SB, SB, S0});
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_result", {20'd0, if3.bcd_out}, 32'd0);

        // Signed: most negative and a small negative
        issue3(1'b1, 8'h80, 12'h128, 1'b1, {S1, S2, S8});
        wait_idle();
        issue3(1'b1, 8'hF9, 12'h007, 1'b1, {SB, SM, S7});
        wait_idle();

        // Handshake: start during busy ignored, start in done cycle accepted
        issue3(1'b0, 8'd123, 12'h123, 1'b0, {S1, S2, S3});
        k = cyc;
        repeat (3) @(negedge clk);
        if3.start = 1'b1; if3.bin_in = 8'd1;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (5) @(negedge clk);
        check("hs_done_cycle", cyc, k + 9);
        check("hs_done_high", {31'd0, if3.done}, 32'd1);
        issue3(1'b0, 8'd42, 12'h042, 1'b0, {SB, S4, S2});
        wait_idle();
        check("hold_bcd", {20'd0, if3.bcd_out}, 32'h042);

        // Zero in signed mode: no minus
        issue3(1'b1, 8'd0, 12'h000, 1'b0, {SB, SB, S0});
        wait_idle();

        // Back-to-back with start held high; bin_in changes mid-conversion
        if3.start = 1'b1; if3.sign_mode = 1'b0; if3.bin_in = 8'd7;
        @(negedge clk);
        k = cyc;
        e3.bcd = 12'h007; e3.neg = 1'b0; e3.ovf = 1'b0; e3.seg = {SB, SB, S7};
        e3.done_edge = k + 9; e3.chk_bcd = 1'b1; q3.push_back(e3);
        if3.bin_in = 8'd58;
        repeat (10) @(negedge clk);
        e3.bcd = 12'h058; e3.seg = {SB, S5, S8}; e3.done_edge = k + 19; q3.push_back(e3);
        if3.bin_in = 8'd200;
        repeat (10) @(negedge clk);
        e3.bcd = 12'h200; e3.seg = {S2, S0, S0}; e3.done_edge = k + 29; q3.push_back(e3);
        if3.start = 1'b0;
        wait_idle();

        // Two-digit instance: overflow, largest fit, minus placement, no room for minus
        issue2(1'b0, 8'd100, 8'h00, 1'b0, 1'b1, 1'b0, {SB, SB});
        wait_idle();
        issue2(1'b0, 8'd99, 8'h99, 1'b0, 1'b0, 1'b1, {S9, S9});
        wait_idle();
        issue2(1'b1, 8'hF7, 8'h09, 1'b1, 1'b0, 1'b1, {SM, S9});
        wait_idle();
        issue2(1'b1, 8'h9D, 8'h99, 1'b1, 1'b0, 1'b1, {S9, S9});
        wait_idle();
        issue2(1'b1, 8'h9C, 8'h00, 1'b1, 1'b1, 1'b0, {SB, SB});
        wait_idle();

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
